// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master.
// Holds the FSM state type, the minimum legal half-period and the
// bus-mode constants (mode 0, MSB first) used by spi_master.
package spi_pkg;

  // IDLE: bus released, LOW/HIGH: the two sclk phases of a bit,
  // NEXT: between bytes of one frame, HOLD: cs_n hold after the
  // last byte, GAP: cs_n high before the next frame may start.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    NEXT = 3'd3,
    HOLD = 3'd4,
    GAP  = 3'd5
  } spi_state_t;

  // Smallest half-period that keeps mosi/miso stable across the
  // slave's 2-flop sclk synchronizer.
  localparam int SPI_HALF_PERIOD_MIN = 4;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   tx_valid/tx_ready   byte handshake; tx_data is shifted out MSB first
//   tx_data[7:0]        byte to send
//   tx_last             byte closes the frame, cs_n released after it
//   rx_valid            one-cycle pulse when rx_data is updated
//   rx_data[7:0]        last byte captured from miso
//   busy                a frame is in progress
//   sclk, cs_n, mosi    registered SPI outputs
//   miso                SPI serial input
//
// HALF_PERIOD is the number of clk cycles per sclk half-period
// (legal range SPI_HALF_PERIOD_MIN..255).
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(HALF_PERIOD - 1);

  spi_state_t       state;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             last_q;
  logic             div_tc;

  assign div_tc   = (div == DIV_TC);
  assign tx_ready = (state == IDLE) || (state == NEXT);
  assign busy     = (state != IDLE);

  // Shift register doubles as transmit and receive buffer: miso enters
  // at the LSB on each rising edge while the outgoing bit leaves at the
  // MSB, so after 8 bits it holds the received byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      last_q   <= 1'b0;
      sclk     <= SPI_CPOL;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE, NEXT: begin
          if (tx_valid) begin
            shift   <= tx_data;
            mosi    <= tx_data[7];
            last_q  <= tx_last;
            bit_cnt <= 3'd7;
            div     <= '0;
            cs_n    <= 1'b0;
            state   <= LOW;
          end
        end
        LOW: begin
          if (div_tc) begin
            div   <= '0;
            sclk  <= 1'b1;
            shift <= {shift[6:0], miso};
            // Eighth rising edge completes the received byte.
            if (bit_cnt == 3'd0) begin
              rx_data  <= {shift[6:0], miso};
              rx_valid <= 1'b1;
            end
            state <= HIGH;
          end else begin
            div <= div + 1'b1;
          end
        end
        HIGH: begin
          if (div_tc) begin
            div  <= '0;
            sclk <= 1'b0;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
              // shift[7] already holds the next outgoing bit after the
              // left shift done on the rising edge.
              mosi    <= shift[7];
              state   <= LOW;
            end else begin
              state <= last_q ? HOLD : NEXT;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        HOLD: begin
          if (div_tc) begin
            div   <= '0;
            cs_n  <= 1'b1;
            state <= GAP;
          end else begin
            div <= div + 1'b1;
          end
        end
        GAP: begin
          if (div_tc) begin
            div   <= '0;
            mosi  <= 1'b0;
            state <= IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master (HALF_PERIOD = 4).
// Expected received bytes are queued when a byte is issued; a monitor
// pops and compares on every rx_valid pulse. Timing points are checked
// relative to the acceptance edge.
module tb_spi_master;

  localparam int HP = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  logic       use_loop;
  logic [7:0] slave_preload;
  logic [7:0] slave_reg;

  int tests;
  int fails;
  int sclk_pulses;
  int csn_rises;
  int accept_cnt;
  int glitches;
  logic [7:0] mosi_cap;
  logic [7:0] exp_q[$];

  spi_master #(.HALF_PERIOD(HP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback or a simple mode-0 slave that shifts on sclk falling edges.
  assign miso = use_loop ? mosi : slave_reg[7];

  always @(posedge clk) if (cs_n) slave_reg <= slave_preload;
  always @(negedge sclk) if (!cs_n) slave_reg <= {slave_reg[6:0], 1'b0};

  always @(posedge sclk) begin
    sclk_pulses++;
    mosi_cap = {mosi_cap[6:0], mosi};
  end
  always @(posedge cs_n) csn_rises++;
  always @(posedge clk) if (rst_n && tx_valid && tx_ready) accept_cnt++;
  always @(negedge clk) if (sclk && mosi !== mosi_cap[0]) glitches++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input logic last,
                               input logic [7:0] exp_rx, input bit push);
    int n;
    tx_valid = 1'b1;
    tx_data  = data;
    tx_last  = last;
    if (push) exp_q.push_back(exp_rx);
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("ready_timeout", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic dropValid();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_sclk"},     {31'd0, sclk},     32'd0);
    checkOutput({tag, "_cs_n"},     {31'd0, cs_n},     32'd1);
    checkOutput({tag, "_mosi"},     {31'd0, mosi},     32'd0);
    checkOutput({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    checkOutput({tag, "_busy"},     {31'd0, busy},     32'd0);
    checkOutput({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    checkOutput({tag, "_rx_data"},  {24'd0, rx_data},  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p0, c0, a0, g0;
    tests = 0; fails = 0;
    sclk_pulses = 0; csn_rises = 0; accept_cnt = 0; glitches = 0;
    mosi_cap = '0;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    use_loop = 1'b1; slave_preload = '0;

    // Reset with no stimulus.
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte 0xA5, loopback, closes the frame.
    p0 = sclk_pulses; g0 = glitches;
    applyStimulus(8'hA5, 1'b1, 8'hA5, 1'b1);
    for (int k = 1; k <= 74; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tx_valid = 1'b0;
        checkOutput("a5_cs_fall", {31'd0, cs_n}, 32'd0);
      end
      if (k == 4)  checkOutput("a5_sclk_c4", {31'd0, sclk}, 32'd0);
      if (k == 5)  checkOutput("a5_sclk_c5", {31'd0, sclk}, 32'd1);
      if (k == 60) checkOutput("a5_rxv_c60", {31'd0, rx_valid}, 32'd0);
      if (k == 61) checkOutput("a5_rxv_c61", {31'd0, rx_valid}, 32'd1);
      if (k == 68) checkOutput("a5_cs_c68", {31'd0, cs_n}, 32'd0);
      if (k == 69) checkOutput("a5_cs_c69", {31'd0, cs_n}, 32'd1);
      if (k == 72) checkOutput("a5_rdy_c72", {31'd0, tx_ready}, 32'd0);
      if (k == 73) checkOutput("a5_rdy_c73", {31'd0, tx_ready}, 32'd1);
    end
    checkOutput("a5_mosi_bits", {24'd0, mosi_cap}, 32'hA5);
    checkOutput("a5_sclk_pulses", sclk_pulses - p0, 32'd8);
    checkOutput("a5_mosi_stable", glitches - g0, 32'd0);

    // Two-byte frame with an idle stretch in NEXT.
    p0 = sclk_pulses; c0 = csn_rises; a0 = accept_cnt;
    applyStimulus(8'h3C, 1'b0, 8'h3C, 1'b1);
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      if (k == 64) checkOutput("f_rdy_c64", {31'd0, tx_ready}, 32'd0);
    end
    checkOutput("f_rdy_c65", {31'd0, tx_ready}, 32'd1);
    checkOutput("f_cs_next", {31'd0, cs_n}, 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("f_sclk_next", {31'd0, sclk}, 32'd0);
    applyStimulus(8'hC3, 1'b1, 8'hC3, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      if (k == 4) checkOutput("f_rise_c4", {31'd0, sclk}, 32'd0);
      if (k == 5) checkOutput("f_rise_c5", {31'd0, sclk}, 32'd1);
    end
    waitIdle();
    checkOutput("f_cs_rises", csn_rises - c0, 32'd1);
    checkOutput("f_sclk_pulses", sclk_pulses - p0, 32'd16);
    checkOutput("f_accepts", accept_cnt - a0, 32'd2);

    // Slave returns 0x5A while master sends 0xFF.
    use_loop = 1'b0;
    slave_preload = 8'h5A;
    repeat (2) @(negedge clk);
    applyStimulus(8'hFF, 1'b1, 8'h5A, 1'b1);
    dropValid();
    waitIdle();
    checkOutput("slave_rx_hold", {24'd0, rx_data}, 32'h5A);
    use_loop = 1'b1;

    // Asynchronous reset in the middle of a byte.
    applyStimulus(8'h96, 1'b1, 8'h00, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(8'h69, 1'b1, 8'h69, 1'b1);
    dropValid();
    waitIdle();

    // tx_valid held with changing data while the byte is shifting.
    a0 = accept_cnt;
    applyStimulus(8'h11, 1'b0, 8'h11, 1'b1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!tx_ready && n < 500) begin
        tx_data = 8'($urandom);
        tx_last = 1'b1;
        @(negedge clk);
        n++;
      end
      checkOutput("hold_busy_ready", {31'd0, tx_ready}, 32'd1);
    end
    checkOutput("hold_accepts_mid", accept_cnt - a0, 32'd1);
    applyStimulus(8'h22, 1'b1, 8'h22, 1'b1);
    dropValid();
    waitIdle();
    checkOutput("hold_accepts", accept_cnt - a0, 32'd2);

    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
